sram_64x8: RTL and testbench

Single-port 64-word × 8-bit synchronous static RAM used as the memory under test in the MBIST datapath. It has one shared address bus, a chip select and a combined read/write-bar control. Reads and writes occur on the rising clock edge. The registered output is forced to zero whenever the chip is deselected. The module name is `sram_64x8`; it replaces the bare `sram` instance name in the MBIST hierarchy.

---
 rtl/sram_64x8.sv | 49 ++++
 tb/tb_sram_64x8.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_64x8.sv
// 64-word x 8-bit single-port synchronous RAM with a registered output.
// The output is zeroed on deselect and the whole array clears on async reset.
module sram_64x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       rwbar,
    input  logic [5:0] ramaddr,
    input  logic [7:0] ramin,
    output logic [7:0] ramout
);

    localparam int unsigned DEPTH = 64;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] ramout_q;
    logic [7:0] ramout_d;
    logic       we;

    // Writes go straight through to the output; deselect forces it to zero.
    always_comb begin
        we       = cs & ~rwbar;
        ramout_d = '0;
        if (cs) begin
            if (rwbar) begin
                ramout_d = mem_q[ramaddr];
            end else begin
                ramout_d = ramin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ramout_q <= '0;
        end else begin
            if (we) begin
                mem_q[ramaddr] <= ramin;
            end
            ramout_q <= ramout_d;
        end
    end

    assign ramout = ramout_q;

endmodule

// File: tb/tb_sram_64x8.sv
// Scoreboard-driven bench for sram_64x8: expected read data is queued as each
// operation is driven and compared once the clock edge has produced the output.
module tb_sram_64x8;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       rwbar;
    logic [5:0] ramaddr;
    logic [7:0] ramin;
    logic [7:0] ramout;

    typedef struct {
        logic       c;
        logic       r;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } op_t;

    logic [7:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;

    sram_64x8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .rwbar   (rwbar),
        .ramaddr (ramaddr),
        .ramin   (ramin),
        .ramout  (ramout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, queue the expectation, then settle past the rising edge.
    task automatic drive(input op_t o);
        @(negedge clk);
        cs      = o.c;
        rwbar   = o.r;
        ramaddr = o.a;
        ramin   = o.d;
        exp_q.push_back(o.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op_t        ops [3];
        logic [7:0] e;
        cs = 1'b0; rwbar = 1'b1; ramaddr = '0; ramin = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ramout !== 8'h00) begin
            bad++;
            $display("FAIL reset_async ramout=%02h exp=00", ramout);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ramout !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold cycle=%0d ramout=%02h exp=00", i, ramout);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        ops[0] = '{1'b1, 1'b1, 6'd0,  8'h00, 8'h00};
        ops[1] = '{1'b1, 1'b1, 6'd17, 8'h00, 8'h00};
        ops[2] = '{1'b1, 1'b1, 6'd63, 8'h00, 8'h00};
        foreach (ops[i]) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL reset_read addr=%0d ramout=%02h exp=%02h", ops[i].a, ramout, e);
            end
        end
    endtask

    task automatic test_write_read();
        op_t        ops [2];
        logic [7:0] e;
        ops[0] = '{1'b1, 1'b0, 6'd42, 8'hA5, 8'hA5};
        ops[1] = '{1'b1, 1'b1, 6'd42, 8'h00, 8'hA5};
        foreach (ops[i]) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL write_read step=%0d ramout=%02h exp=%02h", i, ramout, e);
            end
        end
    endtask

    task automatic test_deselect();
        op_t        ops [3];
        logic [7:0] e;
        ops[0] = '{1'b0, 1'b1, 6'd42, 8'h77, 8'h00};
        ops[1] = '{1'b0, 1'b1, 6'd5,  8'h11, 8'h00};
        ops[2] = '{1'b1, 1'b1, 6'd42, 8'h00, 8'hA5};
        foreach (ops[i]) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL deselect step=%0d ramout=%02h exp=%02h", i, ramout, e);
            end
        end
    endtask

    task automatic test_no_write_deselected();
        op_t        ops [2];
        logic [7:0] e;
        ops[0] = '{1'b0, 1'b0, 6'd42, 8'h3C, 8'h00};
        ops[1] = '{1'b1, 1'b1, 6'd42, 8'h00, 8'hA5};
        foreach (ops[i]) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL no_write_desel step=%0d ramout=%02h exp=%02h", i, ramout, e);
            end
        end
    endtask

    task automatic test_boundaries();
        op_t        ops [7];
        logic [7:0] e;
        ops[0] = '{1'b1, 1'b0, 6'd0,  8'h01, 8'h01};
        ops[1] = '{1'b1, 1'b0, 6'd63, 8'hFF, 8'hFF};
        ops[2] = '{1'b1, 1'b0, 6'd32, 8'h80, 8'h80};
        ops[3] = '{1'b1, 1'b1, 6'd0,  8'h00, 8'h01};
        ops[4] = '{1'b1, 1'b1, 6'd63, 8'h00, 8'hFF};
        ops[5] = '{1'b1, 1'b1, 6'd32, 8'h00, 8'h80};
        ops[6] = '{1'b1, 1'b1, 6'd1,  8'h00, 8'h00};
        foreach (ops[i]) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL boundary step=%0d addr=%0d ramout=%02h exp=%02h", i, ops[i].a, ramout, e);
            end
        end
    endtask

    task automatic test_async_reset();
        op_t        ops [4];
        logic [7:0] e;
        ops[0] = '{1'b1, 1'b1, 6'd63, 8'h00, 8'hFF};
        drive(ops[0]);
        e = exp_q.pop_front();
        total++;
        if (ramout !== e) begin
            bad++;
            $display("FAIL async_pre ramout=%02h exp=%02h", ramout, e);
        end
        // Pulse reset strictly between clock edges.
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (ramout !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_out ramout=%02h exp=00", ramout);
        end
        #1 rst_n = 1'b1;
        ops[1] = '{1'b1, 1'b1, 6'd0,  8'h00, 8'h00};
        ops[2] = '{1'b1, 1'b1, 6'd32, 8'h00, 8'h00};
        ops[3] = '{1'b1, 1'b1, 6'd63, 8'h00, 8'h00};
        for (int i = 1; i < 4; i++) begin
            drive(ops[i]);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL async_reset_read addr=%0d ramout=%02h exp=%02h", ops[i].a, ramout, e);
            end
        end
    endtask

    // Memory is all-zero on entry (follows the async reset test).
    task automatic test_back_to_back();
        logic [7:0] model [64];
        op_t        o;
        logic [7:0] e;
        foreach (model[i]) model[i] = 8'h00;
        for (int i = 0; i < 300; i++) begin
            o.c = ($urandom_range(0, 4) != 0);
            o.r = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       o.a = 6'd0;
                1:       o.a = 6'd63;
                default: o.a = 6'($urandom_range(0, 7));
            endcase
            o.d = 8'($urandom_range(0, 255));
            if (!o.c) begin
                o.e = 8'h00;
            end else if (!o.r) begin
                o.e = o.d;
                model[o.a] = o.d;
            end else begin
                o.e = model[o.a];
            end
            drive(o);
            e = exp_q.pop_front();
            total++;
            if (ramout !== e) begin
                bad++;
                $display("FAIL b2b i=%0d cs=%0b rw=%0b addr=%0d ramout=%02h exp=%02h",
                         i, o.c, o.r, o.a, ramout, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_deselect();
        test_no_write_deselected();
        test_boundaries();
        test_async_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover size=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
